// File: rtl/uart_term_bridge.sv
// UART-to-LCD-terminal bridge: buffers received bytes, dispatches them as
// putchar/clearhome pulses gated by the terminal busy flag, optionally echoing.
module uart_term_bridge #(
  parameter int                DATA_W      = 8,
  parameter int                FIFO_DEPTH  = 16,
  parameter int                ECHO_EN     = 1,
  parameter logic [DATA_W-1:0] CLEAR_CHAR  = 'h0C,
  parameter int                FILTER_CTRL = 1,
  parameter int                HOLD_CYCLES = 2
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [DATA_W-1:0]               s_axis_tdata,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  output logic [DATA_W-1:0]               m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  input  logic                            i_term_busy,
  output logic [DATA_W-1:0]               o_char,
  output logic                            o_putchar,
  output logic                            o_clearhome,
  output logic [$clog2(FIFO_DEPTH):0]     o_level,
  output logic [15:0]                     o_rx_count
);

  localparam int                AW        = $clog2(FIFO_DEPTH);
  localparam int                LW        = AW + 1;
  localparam logic [LW-1:0]     FULL_LVL  = LW'(FIFO_DEPTH);
  localparam logic [DATA_W-1:0] CTRL_LIM  = DATA_W'(32);
  localparam logic [3:0]        HOLD_INIT = 4'(HOLD_CYCLES);

  typedef enum logic [1:0] {IDLE, ECHO, HOLD} state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]       r_wptr, r_rptr;
  logic [LW-1:0]       r_level;
  logic [15:0]         r_rx_count;
  logic [3:0]          r_hold;
  logic [DATA_W-1:0]   r_char, r_mtdata;
  logic                r_putchar, r_clearhome, r_mtvalid;

  logic                w_push, w_pop, w_is_ctrl;
  logic [DATA_W-1:0]   w_head;
  logic [3:0]          w_hold_nxt;

  assign s_axis_tready = (r_level != FULL_LVL);
  assign w_push        = s_axis_tvalid && s_axis_tready;
  assign w_pop         = (r_state == IDLE) && (r_level != '0) && !i_term_busy;
  assign w_head        = r_mem[r_rptr];
  assign w_is_ctrl     = (FILTER_CTRL != 0) && (w_head < CTRL_LIM);
  // Leave HOLD on the edge where the counter reaches zero so pulses are
  // spaced HOLD_CYCLES+1 apart.
  assign w_hold_nxt    = (r_hold == 4'd0) ? 4'd0 : r_hold - 4'd1;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= s_axis_tdata;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_rx_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_level <= r_level + 1'b1;
      else if (!w_push && w_pop) r_level <= r_level - 1'b1;
      if (w_push && (r_rx_count != 16'hFFFF)) r_rx_count <= r_rx_count + 16'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_hold      <= '0;
      r_char      <= '0;
      r_putchar   <= 1'b0;
      r_clearhome <= 1'b0;
      r_mtdata    <= '0;
      r_mtvalid   <= 1'b0;
    end else begin
      r_putchar   <= 1'b0;
      r_clearhome <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_char <= w_head;
            r_hold <= HOLD_INIT;
            if (w_head == CLEAR_CHAR) r_clearhome <= 1'b1;
            else if (!w_is_ctrl)      r_putchar   <= 1'b1;
            if (ECHO_EN != 0) begin
              r_mtdata  <= w_head;
              r_mtvalid <= 1'b1;
              r_state   <= ECHO;
            end else begin
              r_state   <= HOLD;
            end
          end
        end
        ECHO: begin
          if (m_axis_tready) begin
            r_mtvalid <= 1'b0;
            r_state   <= HOLD;
          end
        end
        HOLD: begin
          r_hold <= w_hold_nxt;
          if ((w_hold_nxt == 4'd0) && !i_term_busy) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_char        = r_char;
  assign o_putchar     = r_putchar;
  assign o_clearhome   = r_clearhome;
  assign m_axis_tdata  = r_mtdata;
  assign m_axis_tvalid = r_mtvalid;
  assign o_level       = r_level;
  assign o_rx_count    = r_rx_count;

endmodule
